dmem_lsu: RTL

- Load/store unit between the RV32I core's memory stage and the byte-enabled single-port data SRAM.
- Stores: generates word address, byte-lane write enables and lane-replicated write data.
- Loads: issues the read, waits for the SRAM's 1-cycle registered read and valid flag, then extracts and sign/zero-extends the addressed byte or halfword.
- Detects misaligned, out-of-range and illegal-width accesses and returns an error instead of touching memory.

---
 rtl/dmem_lsu_pkg.sv | 41 ++++
 rtl/dmem_load_align.sv | 36 +++
 rtl/dmem_lsu.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: width codes,
// FSM states and the access-legality decoder.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    ST_ISSUE,
    LD_ISSUE,
    LD_WAIT,
    ERR_RESP
  } state_t;

  // Returns {illegal, misaligned}; unsigned widths are load-only.
  function automatic logic [1:0] decode_access(input logic       wr,
                                               input logic [2:0] funct3,
                                               input logic [1:0] b);
    logic illegal;
    logic misaligned;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:    misaligned = 1'b0;
      F3_BU:   illegal    = wr;
      F3_H:    misaligned = b[0];
      F3_HU: begin
        illegal    = wr;
        misaligned = b[0];
      end
      F3_W:    misaligned = (b != 2'b00);
      default: illegal    = 1'b1;
    endcase
    return {illegal, misaligned};
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/halfword of an SRAM read word and
// sign- or zero-extends it to 32 bits.
module dmem_load_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  b,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[7:0];
    case (b)
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = b[1] ? word[31:16] : word[15:0];

    result = word;
    case (funct3)
      F3_B:    result = {{24{byte_v[7]}}, byte_v};
      F3_BU:   result = {24'h0, byte_v};
      F3_H:    result = {{16{half_v[15]}}, half_v};
      F3_HU:   result = {16'h0, half_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core memory stage and a byte-enabled
// single-port SRAM with a 1-cycle registered read.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    SRAM_DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_REQ,
  input  logic                  i_WR,
  input  logic [2:0]            i_FUNCT3,
  input  logic [ADDR_WIDTH-1:0] i_ADDR,
  input  logic [31:0]           i_WDATA,
  output logic                  o_BUSY,
  output logic                  o_ACK,
  output logic                  o_ERR,
  output logic [31:0]           o_RDATA,
  output logic                  o_MEM_CE,
  output logic [ADDR_WIDTH-1:0] o_MEM_ADDR,
  output logic [31:0]           o_MEM_WDATA,
  output logic [3:0]            o_MEM_WE,
  input  logic [31:0]           i_MEM_RDATA,
  input  logic                  i_MEM_VALID
);

  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(4 * SRAM_DEPTH);

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mem_ce_q, mem_ce_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic [1:0]            b_q, b_d;
  logic [2:0]            funct3_q, funct3_d;

  logic [ADDR_WIDTH-1:0] off;
  logic [1:0]            b_in;
  logic                  out_of_range;
  logic                  illegal;
  logic                  misaligned;
  logic [31:0]           load_result;

  // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
  assign off          = i_ADDR - BASE_ADDR;
  assign b_in         = off[1:0];
  assign out_of_range = ({1'b0, off} >= LIMIT);
  assign {illegal, misaligned} = decode_access(i_WR, i_FUNCT3, b_in);

  dmem_load_align u_align (
    .word   (i_MEM_RDATA),
    .b      (b_q),
    .funct3 (funct3_q),
    .result (load_result)
  );

  // Outputs are computed for the state being entered and registered, so
  // every memory-side and core-side signal is a clean flop output.
  always_comb begin
    state_d     = state_q;
    busy_d      = 1'b0;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = 32'h0;
    mem_ce_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = 32'h0;
    mem_we_d    = 4'h0;
    b_d         = b_q;
    funct3_d    = funct3_q;

    case (state_q)
      IDLE: begin
        if (i_REQ) begin
          busy_d = 1'b1;
          if (out_of_range || illegal || misaligned) begin
            state_d = ERR_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else if (i_WR) begin
            state_d    = ST_ISSUE;
            ack_d      = 1'b1;
            mem_ce_d   = 1'b1;
            mem_addr_d = off >> 2;
            case (i_FUNCT3)
              F3_B: begin
                mem_wdata_d = {4{i_WDATA[7:0]}};
                mem_we_d    = 4'b0001 << b_in;
              end
              F3_H: begin
                mem_wdata_d = {2{i_WDATA[15:0]}};
                mem_we_d    = 4'b0011 << b_in;
              end
              default: begin
                mem_wdata_d = i_WDATA;
                mem_we_d    = 4'b1111;
              end
            endcase
          end else begin
            state_d    = LD_ISSUE;
            mem_ce_d   = 1'b1;
            mem_addr_d = off >> 2;
            b_d        = b_in;
            funct3_d   = i_FUNCT3;
          end
        end
      end
      ST_ISSUE: state_d = IDLE;
      ERR_RESP: state_d = IDLE;
      LD_ISSUE: begin
        state_d = LD_WAIT;
        busy_d  = 1'b1;
      end
      LD_WAIT: begin
        busy_d = 1'b1;
        if (i_MEM_VALID) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          rdata_d = load_result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_ce_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 4'h0;
      b_q         <= 2'b00;
      funct3_q    <= 3'b000;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_ce_q    <= mem_ce_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      b_q         <= b_d;
      funct3_q    <= funct3_d;
    end
  end

  assign o_BUSY      = busy_q;
  assign o_ACK       = ack_q;
  assign o_ERR       = err_q;
  assign o_RDATA     = rdata_q;
  assign o_MEM_CE    = mem_ce_q;
  assign o_MEM_ADDR  = mem_addr_q;
  assign o_MEM_WDATA = mem_wdata_q;
  assign o_MEM_WE    = mem_we_q;

endmodule
